pipe_adder: RTL and testbench



---
 rtl/pipe_adder.sv | 126 ++++++++++++
 tb/tb_pipe_adder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_adder.sv
// Pipelined adder/subtractor with NZCV flags; carry chain split into SEG-bit segments, one register per segment.
// Latency: WIDTH/SEG cycles from accepting edge to visible result; one result per clock when unstalled.
// Backpressure: whole pipeline freezes while out_valid && !out_ready; in_ready = !out_valid || out_ready.
module pipe_adder #(
  parameter int WIDTH = 12,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             c,
  output logic             v,
  output logic             n,
  output logic             z
);

  localparam int STAGES = WIDTH / SEG;

  // Per-stage registers: index i is pipeline stage i+1.
  logic             vld_q [STAGES];
  logic             cry_q [STAGES];
  logic [WIDTH-1:0] res_q [STAGES];
  logic [WIDTH-1:0] opa_q [STAGES];
  logic [WIDTH-1:0] opb_q [STAGES];
  logic             v_q, n_q, z_q;

  // Values feeding each stage (from the inputs for stage 1, else from the previous stage).
  logic             src_vld [STAGES];
  logic             src_cry [STAGES];
  logic [WIDTH-1:0] src_res [STAGES];
  logic [WIDTH-1:0] src_a   [STAGES];
  logic [WIDTH-1:0] src_b   [STAGES];
  logic [SEG:0]     sum_t   [STAGES];
  logic [WIDTH-1:0] res_d   [STAGES];

  logic [WIDTH-1:0] bx;
  logic [WIDTH-1:0] yfin;
  logic             adv;
  logic             cmsb;
  logic             v_d, n_d, z_d;

  // Effective B operand and the global advance shared by every stage.
  always_comb begin
    bx  = sub ? ~b : b;
    adv = !vld_q[STAGES-1] || out_ready;
  end

  assign in_ready = adv;

  // Each stage resolves one segment: stage i adds operand segment i plus the incoming carry.
  always_comb begin
    for (int i = 0; i < STAGES; i++) begin
      if (i == 0) begin
        src_vld[i] = in_valid;
        src_cry[i] = ci;
        src_res[i] = '0;
        src_a[i]   = a;
        src_b[i]   = bx;
      end else begin
        src_vld[i] = vld_q[(i == 0) ? 0 : i-1];
        src_cry[i] = cry_q[(i == 0) ? 0 : i-1];
        src_res[i] = res_q[(i == 0) ? 0 : i-1];
        src_a[i]   = opa_q[(i == 0) ? 0 : i-1];
        src_b[i]   = opb_q[(i == 0) ? 0 : i-1];
      end
      sum_t[i] = {1'b0, src_a[i][i*SEG +: SEG]}
               + {1'b0, src_b[i][i*SEG +: SEG]}
               + {{SEG{1'b0}}, src_cry[i]};
      res_d[i] = src_res[i];
      res_d[i][i*SEG +: SEG] = sum_t[i][SEG-1:0];
    end
  end

  // Flags are derived from the final stage's inputs so they register alongside Y.
  always_comb begin
    yfin = res_d[STAGES-1];
    // Carry into the MSB recovered from the MSB sum bit and the two operand MSBs.
    cmsb = yfin[WIDTH-1] ^ src_a[STAGES-1][WIDTH-1] ^ src_b[STAGES-1][WIDTH-1];
    v_d  = cmsb ^ sum_t[STAGES-1][SEG];
    n_d  = yfin[WIDTH-1];
    z_d  = (yfin == '0);
  end

  // All stages shift together on adv (bubbles included) and hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        vld_q[i] <= 1'b0;
        cry_q[i] <= 1'b0;
        res_q[i] <= '0;
        opa_q[i] <= '0;
        opb_q[i] <= '0;
      end
      v_q <= 1'b0;
      n_q <= 1'b0;
      z_q <= 1'b0;
    end else if (adv) begin
      for (int i = 0; i < STAGES; i++) begin
        vld_q[i] <= src_vld[i];
        cry_q[i] <= sum_t[i][SEG];
        res_q[i] <= res_d[i];
        opa_q[i] <= src_a[i];
        opb_q[i] <= src_b[i];
      end
      v_q <= v_d;
      n_q <= n_d;
      z_q <= z_d;
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign y         = res_q[STAGES-1];
  assign c         = cry_q[STAGES-1];
  assign v         = v_q;
  assign n         = n_q;
  assign z         = z_q;

endmodule

// File: tb/tb_pipe_adder.sv
// Directed and streaming bench for pipe_adder, plus an edge-value sweep over three other geometries.
// Latency: checks the 3-cycle default latency on every directed vector.
// Backpressure: random out_ready in the stream; stalled outputs must hold.
module tb_pipe_adder;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [11:0] a, b, y;
  logic        ci, sub, c, v, n, z;

  int tests;
  int fails;

  pipe_adder #(.WIDTH(12), .SEG(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ci(ci), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .c(c), .v(v), .n(n), .z(z)
  );

  // Shared stimulus for the geometry sweep instances.
  logic [15:0] sw_a, sw_b;
  logic        sw_ci, sw_sub, sw_valid, sw_ordy;
  logic        r8a, r8b, r16;
  logic        o8a_vld, o8b_vld, o16_vld;
  logic [7:0]  o8a_y, o8b_y;
  logic [15:0] o16_y;
  logic        o8a_c, o8a_v, o8a_n, o8a_z;
  logic        o8b_c, o8b_v, o8b_n, o8b_z;
  logic        o16_c, o16_v, o16_n, o16_z;

  pipe_adder #(.WIDTH(8), .SEG(8)) u8a (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(r8a),
    .a(sw_a[7:0]), .b(sw_b[7:0]), .ci(sw_ci), .sub(sw_sub), .out_valid(o8a_vld), .out_ready(sw_ordy),
    .y(o8a_y), .c(o8a_c), .v(o8a_v), .n(o8a_n), .z(o8a_z)
  );
  pipe_adder #(.WIDTH(8), .SEG(2)) u8b (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(r8b),
    .a(sw_a[7:0]), .b(sw_b[7:0]), .ci(sw_ci), .sub(sw_sub), .out_valid(o8b_vld), .out_ready(sw_ordy),
    .y(o8b_y), .c(o8b_c), .v(o8b_v), .n(o8b_n), .z(o8b_z)
  );
  pipe_adder #(.WIDTH(16), .SEG(4)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(r16),
    .a(sw_a), .b(sw_b), .ci(sw_ci), .sub(sw_sub), .out_valid(o16_vld), .out_ready(sw_ordy),
    .y(o16_y), .c(o16_c), .v(o16_v), .n(o16_n), .z(o16_z)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Capture each sweep instance's results as {c,v,n,z,y16}.
  int          cnt8a, cnt8b, cnt16;
  logic [19:0] cap8a, cap8b, cap16;
  always @(negedge clk) begin
    if (o8a_vld) begin cnt8a <= cnt8a + 1; cap8a <= {o8a_c, o8a_v, o8a_n, o8a_z, 8'h00, o8a_y}; end
    if (o8b_vld) begin cnt8b <= cnt8b + 1; cap8b <= {o8b_c, o8b_v, o8b_n, o8b_z, 8'h00, o8b_y}; end
    if (o16_vld) begin cnt16 <= cnt16 + 1; cap16 <= {o16_c, o16_v, o16_n, o16_z, o16_y}; end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp_v);
    end
  endtask

  // Reference: {c, v, n, z, y} for a w-bit add/subtract, y zero-extended to 16 bits.
  function automatic logic [19:0] model(input int w, input logic [15:0] ma, input logic [15:0] mb,
                                        input logic mci, input logic msub);
    logic [16:0] mask, aa, bb, s;
    logic [15:0] yy;
    logic        cc, vv, nn, zz;
    mask = (17'd1 << w) - 17'd1;
    aa   = {1'b0, ma} & mask;
    bb   = {1'b0, (msub ? ~mb : mb)} & mask;
    s    = aa + bb + {16'd0, mci};
    yy   = s[15:0] & mask[15:0];
    cc   = s[w];
    nn   = yy[w-1];
    zz   = (yy == 16'd0);
    vv   = (aa[w-1] == bb[w-1]) && (yy[w-1] != aa[w-1]);
    return {cc, vv, nn, zz, yy};
  endfunction

  function automatic logic [15:0] edge_val(input int sel, input int w);
    logic [16:0] m;
    m = (17'd1 << w) - 17'd1;
    if (sel == 0) return 16'd0;
    if (sel == 1) return m[15:0];
    return m[15:0] ^ (m[15:0] >> 1);
  endfunction

  // One isolated transaction with hand-computed expectations and a latency check.
  task automatic run_one(input string tag, input logic [11:0] ta, input logic [11:0] tb_v,
                         input logic tci, input logic tsub, input logic [11:0] ey,
                         input logic ec, input logic ev, input logic en, input logic ez);
    @(negedge clk);
    a = ta; b = tb_v; ci = tci; sub = tsub; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; a = 12'($urandom); b = 12'($urandom); ci = 1'($urandom); sub = 1'($urandom);
    check({tag, " early0"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    check({tag, " early1"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    check({tag, " valid"}, 32'(out_valid), 32'd1);
    check({tag, " y"}, 32'(y), 32'(ey));
    check({tag, " c"}, 32'(c), 32'(ec));
    check({tag, " v"}, 32'(v), 32'(ev));
    check({tag, " n"}, 32'(n), 32'(en));
    check({tag, " z"}, 32'(z), 32'(ez));
  endtask

  initial begin
    logic [19:0] q[$];
    logic [19:0] exp_r, prev_out;
    logic        prev_stall;
    int          sent, recv, seen, w, b8a, b8b, b16;
    logic [15:0] va, vb;

    tests = 0; fails = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; ci = 1'b0; sub = 1'b0;
    sw_a = '0; sw_b = '0; sw_ci = 1'b0; sw_sub = 1'b0; sw_valid = 1'b0; sw_ordy = 1'b1;

    // Reset held with random traffic on the inputs.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'($urandom); out_ready = 1'($urandom);
      a = 12'($urandom); b = 12'($urandom); ci = 1'($urandom); sub = 1'($urandom);
    end
    #1;
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst y", 32'(y), 32'd0);
    check("rst cvnz", 32'({c, v, n, z}), 32'd0);
    check("rst in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1; rst_n = 1'b1;

    run_one("add 7ff+1", 12'h7FF, 12'h001, 1'b0, 1'b0, 12'h800, 1'b0, 1'b1, 1'b1, 1'b0);
    run_one("add fff+1", 12'hFFF, 12'h001, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 1'b1);
    run_one("sub 5-7",   12'h005, 12'h007, 1'b1, 1'b1, 12'hFFE, 1'b0, 1'b0, 1'b1, 1'b0);
    run_one("sub 800-1", 12'h800, 12'h001, 1'b1, 1'b1, 12'h7FF, 1'b1, 1'b1, 1'b0, 1'b0);
    run_one("ripple 0ff+1", 12'h0FF, 12'h001, 1'b0, 1'b0, 12'h100, 1'b0, 1'b0, 1'b0, 1'b0);
    run_one("ci only",   12'h000, 12'h000, 1'b1, 1'b0, 12'h001, 1'b0, 1'b0, 1'b0, 1'b0);

    // Fill the pipeline with three stalled transactions, then reset mid-flight.
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; a = 12'h123; b = 12'h456;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    check("flight full", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async rst", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("flushed", 32'(seen), 32'd0);

    // Streaming with random backpressure against the reference model.
    sent = 0; recv = 0; prev_stall = 1'b0; prev_out = '0;
    for (int cyc = 0; cyc < 400 && recv < 20; cyc++) begin
      @(negedge clk);
      in_valid  = (sent < 20);
      a = 12'($urandom); b = 12'($urandom); ci = 1'($urandom); sub = 1'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      check("in_ready==adv", 32'(in_ready), 32'(!out_valid || out_ready));
      if (prev_stall) check("stall hold", 32'({c, v, n, z, 4'h0, y}), 32'(prev_out));
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("stream extra", 32'd1, 32'(q.size()));
        end else begin
          exp_r = q.pop_front();
          check($sformatf("stream #%0d", recv), 32'({c, v, n, z, 4'h0, y}), 32'(exp_r));
        end
        recv++;
      end
      if (in_valid && in_ready) begin
        q.push_back(model(12, {4'h0, a}, {4'h0, b}, ci, sub));
        sent++;
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = {c, v, n, z, 4'h0, y};
    end
    check("stream count", 32'(recv), 32'd20);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;

    // Edge values (0, max, MSB-only) across (8,8), (8,2) and (16,4).
    for (int wi = 0; wi < 2; wi++) begin
      w = (wi == 0) ? 8 : 16;
      for (int as = 0; as < 3; as++) begin
        for (int bs = 0; bs < 3; bs++) begin
          for (int sb = 0; sb < 2; sb++) begin
            va = edge_val(as, w); vb = edge_val(bs, w);
            b8a = cnt8a; b8b = cnt8b; b16 = cnt16;
            @(negedge clk);
            sw_a = va; sw_b = vb; sw_sub = 1'(sb); sw_ci = 1'(sb); sw_valid = 1'b1;
            @(negedge clk);
            sw_valid = 1'b0;
            repeat (5) @(negedge clk);
            #1;
            exp_r = model(w, va, vb, 1'(sb), 1'(sb));
            if (w == 8) begin
              check($sformatf("sw8x8 a%0d b%0d s%0d cnt", as, bs, sb), 32'(cnt8a - b8a), 32'd1);
              check($sformatf("sw8x8 a%0d b%0d s%0d", as, bs, sb), 32'(cap8a), 32'(exp_r));
              check($sformatf("sw8x2 a%0d b%0d s%0d cnt", as, bs, sb), 32'(cnt8b - b8b), 32'd1);
              check($sformatf("sw8x2 a%0d b%0d s%0d", as, bs, sb), 32'(cap8b), 32'(exp_r));
            end else begin
              check($sformatf("sw16x4 a%0d b%0d s%0d cnt", as, bs, sb), 32'(cnt16 - b16), 32'd1);
              check($sformatf("sw16x4 a%0d b%0d s%0d", as, bs, sb), 32'(cap16), 32'(exp_r));
            end
          end
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
